led_fade_driver: RTL and testbench

//  Output stage for one LED channel, placed directly downstream of flash_module.

---
 rtl/led_fade_driver.sv | 138 +++++++++++++
 tb/tb_led_fade_driver.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_driver.sv
// led_fade_driver: PWM output stage for one LED channel with a linear soft fade.
// Sits directly after flash_module. It turns the blink square wave into a
// brightness-controlled, registered pin drive.
module led_fade_driver #(
  parameter logic [21:0] FADE_TICK  = 22'd49_999,
  parameter logic        ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       LED_In,
  input  logic       Enable,
  input  logic [1:0] Mode,
  input  logic [7:0] Duty_Max,
  output logic       LED_Pin,
  output logic [7:0] Level,
  output logic       Busy
);

  localparam logic [1:0] MODE_OFF         = 2'b00;
  localparam logic [1:0] MODE_ON          = 2'b01;
  localparam logic [1:0] MODE_FOLLOW      = 2'b10;
  localparam logic [1:0] MODE_FOLLOW_HARD = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] tick_q, tick_d;
  logic [7:0]  level_q, level_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        rin_q, rin_d;
  logic        pin_q, pin_d;

  logic [7:0]  target;
  logic        pwm_on;
  logic        busy;

  // Brightness the channel is heading toward, taken from the registered blink input
  always_comb begin
    target = 8'd0;
    if (Enable) begin
      case (Mode)
        MODE_ON:          target = Duty_Max;
        MODE_FOLLOW,
        MODE_FOLLOW_HARD: target = rin_q ? Duty_Max : 8'd0;
        default:          target = 8'd0;
      endcase
    end
  end

  // Next-state logic: fade FSM, tick divider and level stepping
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    level_d = level_q;
    if (!Enable) begin
      state_d = IDLE;
      tick_d  = 22'd0;
      level_d = 8'd0;
    end else if (Mode == MODE_FOLLOW_HARD) begin
      state_d = IDLE;
      tick_d  = 22'd0;
      level_d = target;
    end else begin
      case (state_q)
        IDLE: begin
          tick_d = 22'd0;
          if (target > level_q) begin
            state_d = RAMP_UP;
          end else if (target < level_q) begin
            state_d = RAMP_DOWN;
          end
        end
        RAMP_UP, RAMP_DOWN: begin
          if (tick_q == FADE_TICK) begin
            // A step always heads toward the current target, so a target
            // change mid-ramp reverses direction without restarting the tick.
            tick_d = 22'd0;
            if (level_q < target) begin
              level_d = level_q + 8'd1;
            end else if (level_q > target) begin
              level_d = level_q - 8'd1;
            end
            if (level_d < target) begin
              state_d = RAMP_UP;
            end else if (level_d > target) begin
              state_d = RAMP_DOWN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 22'd1;
          end
        end
        default: begin
          state_d = IDLE;
          tick_d  = 22'd0;
        end
      endcase
    end
  end

  // Output logic: busy flag, PWM comparison and the next pin value
  always_comb begin
    busy   = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
    pwm_on = (level_q == 8'd255) ? 1'b1 : (pcnt_q < level_q);
    pin_d  = (pwm_on & Enable) ^ ACTIVE_LOW;
    pcnt_d = pcnt_q + 8'd1;
    rin_d  = LED_In;
  end

  // State and datapath registers, cleared to a dark channel on reset
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      tick_q  <= 22'd0;
      level_q <= 8'd0;
      pcnt_q  <= 8'd0;
      rin_q   <= 1'b0;
      pin_q   <= ACTIVE_LOW;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      pcnt_q  <= pcnt_d;
      rin_q   <= rin_d;
      pin_q   <= pin_d;
    end
  end

  assign LED_Pin = pin_q;
  assign Level   = level_q;
  assign Busy    = busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Testbench for led_fade_driver: behavioural reference model plus directed literal checks
// and a randomized phase. Two instances run side by side, one per pin polarity.
module tb_led_fade_driver;

  localparam logic [21:0] FT = 22'd3;
  localparam int STEP_CLKS = 4;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       LED_In = 1'b0;
  logic       Enable = 1'b0;
  logic [1:0] Mode = 2'b00;
  logic [7:0] Duty_Max = 8'd0;

  logic       pin0, pin1, busy0, busy1;
  logic [7:0] level0, level1;

  int total = 0;
  int bad = 0;

  led_fade_driver #(.FADE_TICK(FT), .ACTIVE_LOW(1'b0)) dut0 (
    .CLK(CLK), .RSTn(RSTn), .LED_In(LED_In), .Enable(Enable), .Mode(Mode),
    .Duty_Max(Duty_Max), .LED_Pin(pin0), .Level(level0), .Busy(busy0)
  );

  led_fade_driver #(.FADE_TICK(FT), .ACTIVE_LOW(1'b1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .LED_In(LED_In), .Enable(Enable), .Mode(Mode),
    .Duty_Max(Duty_Max), .LED_Pin(pin1), .Level(level1), .Busy(busy1)
  );

  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports failures
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural model: brightness as an integer that moves one unit toward the goal
  // every STEP_CLKS clocks once a fade has begun
  int m_level = 0;
  int m_pcnt = 0;
  int m_phase = 0;
  bit m_rin = 1'b0;
  bit m_ramp = 1'b0;
  bit m_pin = 1'b0;

  always @(posedge CLK or negedge RSTn) begin : model_b
    int goal;
    if (!RSTn) begin
      m_level = 0; m_pcnt = 0; m_phase = 0;
      m_rin = 1'b0; m_ramp = 1'b0; m_pin = 1'b0;
    end else begin
      if (!Enable || Mode == 2'b00) goal = 0;
      else if (Mode == 2'b01) goal = Duty_Max;
      else goal = m_rin ? int'(Duty_Max) : 0;
      m_pin = Enable && ((m_level == 255) || (m_pcnt < m_level));
      m_pcnt = (m_pcnt + 1) % 256;
      if (!Enable) begin
        m_level = 0; m_ramp = 1'b0; m_phase = 0;
      end else if (Mode == 2'b11) begin
        m_level = goal; m_ramp = 1'b0; m_phase = 0;
      end else if (!m_ramp) begin
        m_phase = 0;
        if (goal != m_level) m_ramp = 1'b1;
      end else begin
        m_phase++;
        if (m_phase == STEP_CLKS) begin
          m_phase = 0;
          if (goal > m_level) m_level++;
          else if (goal < m_level) m_level--;
          if (m_level == goal) m_ramp = 1'b0;
        end
      end
      m_rin = LED_In;
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    check_output("level0", level0, m_level);
    check_output("level1", level1, m_level);
    check_output("busy0", busy0, m_ramp);
    check_output("busy1", busy1, m_ramp);
    check_output("pin0", pin0, m_pin);
    check_output("pin1", pin1, !m_pin);
  end

  task automatic apply_stimulus(input logic [1:0] mode, input logic [7:0] duty, input logic en, input logic led);
    Mode = mode; Duty_Max = duty; Enable = en; LED_In = led;
  endtask

  task automatic count_pin0(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge CLK);
      cnt += int'(pin0);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int i;
    repeat (2) @(negedge CLK);
    for (i = 0; i < limit && busy0 !== 1'b0; i++) @(negedge CLK);
    check_output(name, busy0, 0);
  endtask

  initial begin
    int cnt;
    int i;
    int r;
    RSTn = 1'b1;
    apply_stimulus(2'b01, 8'd4, 1'b1, 1'b0);
    #1 RSTn = 1'b0;
    #1;
    check_output("reset_level", level0, 0);
    check_output("reset_busy", busy0, 0);
    check_output("reset_pin0", pin0, 0);
    check_output("reset_pin1", pin1, 1);
    @(negedge CLK);
    #2 RSTn = 1'b1;

    // Ramp 0 -> 4 from reset
    for (int k = 1; k <= 17; k++) begin
      @(negedge CLK);
      if (k == 4)  begin check_output("t1_k4_level", level0, 0); check_output("t1_k4_busy", busy0, 1); end
      if (k == 5)  check_output("t1_k5_level", level0, 1);
      if (k == 9)  check_output("t1_k9_level", level0, 2);
      if (k == 13) check_output("t1_k13_level", level0, 3);
      if (k == 16) begin check_output("t1_k16_level", level0, 3); check_output("t1_k16_busy", busy0, 1); end
      if (k == 17) begin check_output("t1_k17_level", level0, 4); check_output("t1_k17_busy", busy0, 0); end
    end
    count_pin0(256, cnt);
    check_output("t1_pin_high_count", cnt, 4);

    // Reset mid-ramp at Level=6
    Duty_Max = 8'd10;
    for (i = 0; i < 200 && level0 !== 8'd6; i++) @(negedge CLK);
    check_output("t2_reach6", level0, 6);
    #2 RSTn = 1'b0;
    #1;
    check_output("t2_rst_level", level0, 0);
    check_output("t2_rst_busy", busy0, 0);
    check_output("t2_rst_pin0", pin0, 0);
    check_output("t2_rst_pin1", pin1, 1);
    @(negedge CLK);
    #2 RSTn = 1'b1;
    repeat (5) @(negedge CLK);
    check_output("t2_restart_level", level0, 1);

    // Hard follow
    apply_stimulus(2'b11, 8'd200, 1'b1, 1'b0);
    repeat (4) @(negedge CLK);
    LED_In = 1'b1;
    @(negedge CLK);
    check_output("t3_rise_plus1", level0, 0);
    @(negedge CLK);
    check_output("t3_rise_plus2", level0, 200);
    check_output("t3_busy", busy0, 0);
    LED_In = 1'b0;
    @(negedge CLK);
    check_output("t3_fall_plus1", level0, 200);
    @(negedge CLK);
    check_output("t3_fall_plus2", level0, 0);

    // Full and zero brightness
    apply_stimulus(2'b01, 8'd255, 1'b1, 1'b0);
    wait_idle("t4_up_done", 1500);
    check_output("t4_level255", level0, 255);
    count_pin0(256, cnt);
    check_output("t4_pin_full", cnt, 256);
    Duty_Max = 8'd0;
    wait_idle("t4_down_done", 1500);
    check_output("t4_level0", level0, 0);
    count_pin0(256, cnt);
    check_output("t4_pin_dark", cnt, 0);

    // Mode to OFF partway up a ramp toward 10
    Duty_Max = 8'd10;
    for (i = 0; i < 200 && level0 !== 8'd6; i++) @(negedge CLK);
    check_output("t5_reach6", level0, 6);
    Mode = 2'b00;
    wait_idle("t5_down_done", 200);
    check_output("t5_level0", level0, 0);

    // Enable low on the active-low instance
    apply_stimulus(2'b01, 8'd50, 1'b1, 1'b0);
    repeat (40) @(negedge CLK);
    Enable = 1'b0;
    @(negedge CLK);
    check_output("t6_level0", level0, 0);
    check_output("t6_level1", level1, 0);
    cnt = 0;
    repeat (50) begin
      @(negedge CLK);
      cnt += int'(pin1);
    end
    check_output("t6_pin1_high", cnt, 50);

    // Randomized phase, checked by the model every cycle
    Enable = 1'b1;
    repeat (4000) begin
      @(negedge CLK);
      r = $urandom_range(0, 99);
      if (r < 20) LED_In = ~LED_In;
      else if (r < 23) Mode = 2'($urandom_range(0, 3));
      else if (r < 25) Duty_Max = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 16));
      else if (r == 25) Enable = 1'b0;
      else if (r < 31 && !Enable) Enable = 1'b1;
      else if (r == 31 && $urandom_range(0, 9) == 0) begin
        #2 RSTn = 1'b0;
        #1 RSTn = 1'b1;
      end
    end

    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
